fetch_stage: RTL

Instruction fetch stage sitting directly upstream of the instruction memory. It owns the program counter, drives the word-indexed instruction memory address, and captures the combinationally returned instruction into an IF/ID output register. The output register has a valid/ready handshake toward decode and accepts PC redirects from branch/jump resolution. It is the first step in moving the core from one-cycle to pipelined operation.

---
 rtl/fetch_stage.sv | 56 +++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses word-indexed instruction memory,
// and registers the returned instruction into a valid/ready IF/ID output register.
module fetch_stage #(
  parameter int unsigned                  PC_WIDTH_LENGTH   = 32,
  parameter int unsigned                  INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC          = '0,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST          = INST_WIDTH_LENGTH'(32'h00000013)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH_LENGTH-1:0]   imem_addr,
  input  logic [INST_WIDTH_LENGTH-1:0] imem_data,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH_LENGTH-1:0]   out_pc,
  output logic [PC_WIDTH_LENGTH-1:0]   out_pc_plus4,
  output logic [INST_WIDTH_LENGTH-1:0] out_inst,
  output logic                         out_misaligned
);

  logic [PC_WIDTH_LENGTH-1:0] pc;
  logic [PC_WIDTH_LENGTH-1:0] pc_plus4;
  logic                       pc_misaligned;
  logic                       take;

  // Memory is word-indexed: drop the byte offset and zero-extend.
  assign imem_addr     = {2'b00, pc[PC_WIDTH_LENGTH-1:2]};
  assign pc_plus4      = pc + PC_WIDTH_LENGTH'(4);
  assign pc_misaligned = |pc[1:0];
  assign take          = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_pc_plus4   <= '0;
      out_inst       <= NOP_INST;
      out_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      // Wrong-path entry is dropped; data fields are left as they were.
      pc        <= redirect_pc;
      out_valid <= 1'b0;
    end else if (take) begin
      pc             <= pc_plus4;
      out_valid      <= 1'b1;
      out_pc         <= pc;
      out_pc_plus4   <= pc_plus4;
      out_inst       <= pc_misaligned ? NOP_INST : imem_data;
      out_misaligned <= pc_misaligned;
    end
  end

endmodule
